// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle radix-2 restoring integer divider for DIV / DIVU.
//            One quotient bit is produced per clock. Execute raises start_i
//            with the operands and holds it until ready_o. The result then
//            stays on result_o until start_i is dropped. annul_i abandons a
//            division that is in progress.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            signed_div_i - 1 = signed DIV, 0 = unsigned DIVU (sampled at start)
//            opdata1_i    - dividend (sampled at start)
//            opdata2_i    - divisor  (sampled at start)
//            start_i      - request, held high until ready_o is seen
//            annul_i      - flush: drop the current division
//            result_o     - {remainder (HI), quotient (LO)}
//            ready_o      - result valid
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int                CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [2*DATA_W:0]      dend_q,    dend_d;
    logic [DATA_W-1:0]      divisor_q, divisor_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]    result_q,  result_d;
    logic                   ready_q,   ready_d;

    logic [DATA_W-1:0]      w_abs1;
    logic [DATA_W-1:0]      w_abs2;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_quo;
    logic [DATA_W-1:0]      w_rem;

    // Magnitudes of the operands. 0x80000000 negates to itself and is then
    // treated as an unsigned magnitude, which gives the wrap-around result.
    always_comb begin
        w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // Trial subtraction of the divisor from the upper partial remainder;
    // the top bit set means the subtraction borrowed.
    always_comb begin
        w_diff = dend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    end

    always_comb begin
        w_quo = neg_quo_q ? (~dend_q[DATA_W-1:0] + 1'b1) : dend_q[DATA_W-1:0];
        w_rem = neg_rem_q ? (~dend_q[2*DATA_W:DATA_W+1] + 1'b1)
                          : dend_q[2*DATA_W:DATA_W+1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dend_d    = dend_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        dend_d    = {{DATA_W{1'b0}}, w_abs1, 1'b0};
                        divisor_d = w_abs2;
                        neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
                    end
                end
            end

            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
                ready_d  = 1'b1;
            end

            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                    ready_d = 1'b0;
                end else if (cnt_q != C_CNT_LAST) begin
                    if (w_diff[DATA_W]) begin
                        dend_d = {dend_q[2*DATA_W-1:0], 1'b0};
                    end else begin
                        dend_d = {w_diff[DATA_W-1:0], dend_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = S_END;
                    result_d = {w_rem, w_quo};
                    ready_d  = 1'b1;
                end
            end

            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            dend_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dend_q    <= dend_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: table of directed divisions
//            with hand-computed results and latencies, plus sequences for
//            annul, start blocked by annul, and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp;
    int n_bad;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Run one division with start held: measure the edge at which ready_o
    // rises, check the result, check it is held for 5 more cycles, then drop
    // start and check the outputs clear on the next edge.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int   got;
        logic stable;
        logic [63:0] res;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        got          = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                // operands after the start edge must not matter
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (ready_o === 1'b1) begin
                got = k;
                break;
            end
        end
        res = result_o;
        chk({name, " latency"}, 64'(got), 64'(lat));
        chk({name, " result"}, res, exp);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b1 || result_o !== res) stable = 1'b0;
        end
        chk({name, " held in END"}, 64'(stable), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " release"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        logic seen;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"divu 100/7",       1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34};
        vecs[1]  = '{"div -7/2",         1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2]  = '{"div 7/-2",         1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
        vecs[3]  = '{"div min/-1",       1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
        vecs[4]  = '{"divu max/1",       1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34};
        vecs[5]  = '{"divu 5/0",         1'b0, 32'd5,        32'd0,        64'h0,                 2};
        vecs[6]  = '{"div -7/0",         1'b1, 32'hFFFFFFF9, 32'd0,        64'h0,                 2};
        vecs[7]  = '{"divu min/max",     1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34};
        vecs[8]  = '{"div -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34};
        vecs[9]  = '{"divu 0/9",         1'b0, 32'd0,        32'd9,        64'h0,                 34};
        vecs[10] = '{"divu 9/4",         1'b0, 32'd9,        32'd4,        64'h00000001_00000002, 34};

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {result_o[62:0], ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // annul at edge 10 of DIVU 1000/3: ready must never rise
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        run_div("divu 9/4 after annul", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 34);

        // start blocked while annul held in FREE
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("annul blocks start", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        // asynchronous reset mid-division at edge 20
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("reset mid-op", {result_o[62:0], ready_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        chk("no ready after reset", 64'(seen), 64'd0);

        // asynchronous reset while holding a result in END
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ready before END reset", 64'(seen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("reset in END", {result_o[62:0], ready_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        run_div("divu 100/7 after reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
